// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/bubble control for load-use, branch, fetch-miss and MUL/DIV hazards
module hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             imem_ready_i,
  input  logic             mdu_start_i,
  output logic             pc_write_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  typedef enum logic {RUN, MDU_WAIT} state_t;
  state_t           r_state, w_next_state;
  logic [7:0]       r_mdu_cnt, w_next_mdu_cnt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_luh, w_freeze;
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= RUN;
      r_mdu_cnt   <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_mdu_cnt   <= w_next_mdu_cnt;
      r_stall_cnt <= (!pc_write_o && !(&r_stall_cnt)) ? r_stall_cnt + CNT_W'(1) : r_stall_cnt;
      r_flush_cnt <= (if_id_flush_o && !(&r_flush_cnt)) ? r_flush_cnt + CNT_W'(1) : r_flush_cnt;
    end
  end
  // MDU_LAT=2 needs only the start cycle frozen, so the wait state is skipped
  always_comb begin
    w_next_state   = r_state;
    w_next_mdu_cnt = r_mdu_cnt;
    if (r_state == RUN) begin
      if (mdu_start_i && MDU_LAT > 2) begin
        w_next_state   = MDU_WAIT;
        w_next_mdu_cnt = 8'(MDU_LAT - 2);
      end
    end else begin
      w_next_mdu_cnt = r_mdu_cnt - 8'd1;
      w_next_state   = (r_mdu_cnt == 8'd1) ? RUN : MDU_WAIT;
    end
  end
  always_comb begin
    w_freeze       = (r_state == MDU_WAIT) || mdu_start_i;
    w_luh          = ex_memread_i && (ex_rt_i != 5'd0) &&
                     ((ex_rt_i == id_rs_i) || (id_uses_rt_i && ex_rt_i == id_rt_i));
    pc_write_o     = rst_i && !w_freeze && !w_luh && (branch_taken_i || imem_ready_i);
    if_id_stall_o  = rst_i && (w_freeze || w_luh);
    if_id_flush_o  = !rst_i || (!w_freeze && !w_luh && (branch_taken_i || !imem_ready_i));
    id_ex_stall_o  = rst_i && w_freeze;
    id_ex_bubble_o = !rst_i || (!w_freeze && w_luh);
  end
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage CPU. It sits beside the IF/ID and ID/EX pipeline registers and the PC, and generates their PC-write, stall, flush and bubble controls. It resolves load-use hazards, taken-branch redirects, instruction-fetch misses and multi-cycle MUL/DIV occupancy of EX. It also keeps saturating stall and flush performance counters.

## Interface
- MDU_LAT, 4: total cycles a MUL/DIV op occupies EX; legal range 2..255.
- CNT_W, 16: width of the performance counters.

- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, synchronous, active-low
- id_rs_i  in  5  rs field of the instruction in ID
- id_rt_i  in  5  rt field of the instruction in ID
- id_uses_rt_i  in  1  ID instruction reads rt as a source
- ex_memread_i  in  1  instruction in EX is a load
- ex_rt_i  in  5  destination register of the load in EX
- branch_taken_i  in  1  branch resolved taken in ID this cycle
- imem_ready_i  in  1  instruction memory returned valid data this cycle
- mdu_start_i  in  1  MUL/DIV op enters its first EX cycle (single-cycle pulse)
- pc_write_o  out  1  PC load enable
- if_id_stall_o  out  1  hold IF/ID contents
- if_id_flush_o  out  1  load NOP (32'd0) into IF/ID
- id_ex_stall_o  out  1  hold ID/EX contents
- id_ex_bubble_o  out  1  load control-zero bubble into ID/EX
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0 since reset; saturating
- flush_cnt_o  out  CNT_W  cycles with if_id_flush_o=1 since reset; saturating

## Operation
- FSM states: RUN, MDU_WAIT. An internal 8-bit down-counter mdu_cnt tracks MDU_WAIT.
- Outputs are combinational from the current state and inputs, so a stall takes effect at the same edge at which the hazard is present. State and counters are registered.
- Default outputs: pc_write_o=1, all others 0.
- Load-use hazard condition (luh): ex_memread_i && ex_rt_i!=0 && (ex_rt_i==id_rs_i || (id_uses_rt_i && ex_rt_i==id_rt_i)).
- Output rules by priority, highest first:
  1. rst_i=0: pc_write_o=0, if_id_flush_o=1, id_ex_bubble_o=1, others 0.
  2. State is MDU_WAIT, or state is RUN with mdu_start_i=1 (freeze): pc_write_o=0, if_id_stall_o=1, id_ex_stall_o=1, flush=0, bubble=0. luh and branch are ignored.
  3. luh: pc_write_o=0, if_id_stall_o=1, id_ex_bubble_o=1. branch_taken_i is ignored because the branch re-resolves next cycle.
  4. branch_taken_i: pc_write_o=1, if_id_flush_o=1. This rule wins over imem_ready_i=0: the PC takes the target and the invalid fetch is discarded.
  5. imem_ready_i=0: pc_write_o=0, if_id_flush_o=1 (NOP injected), ID/EX advances normally.
- FSM transitions:
  - RUN with mdu_start_i=1 and MDU_LAT>2: go to MDU_WAIT, mdu_cnt←MDU_LAT-2.
  - RUN with mdu_start_i=1 and MDU_LAT=2: stay in RUN.
  - In MDU_WAIT, mdu_cnt decrements each cycle. When mdu_cnt==1, go to RUN.
  - mdu_start_i is ignored in MDU_WAIT.
  - Total frozen cycles per MUL/DIV op = MDU_LAT-1.
- Counters:
  - stall_cnt_o increments when rst_i=1 and pc_write_o=0.
  - flush_cnt_o increments when rst_i=1 and if_id_flush_o=1.
  - Both hold at 2^CNT_W-1.

## Timing
- Reset: state←RUN, mdu_cnt←0, stall_cnt_o←0, flush_cnt_o←0 at the first rising edge with rst_i=0. Outputs follow rule 1 for as long as rst_i=0.
- Reset asserted in MDU_WAIT aborts the wait. At the first edge after release, the block is in RUN with no residual freeze.
- Hazard-to-control latency is 0 cycles (combinational). The FSM and counters update at the edge that ends the cycle.
- Load-use: exactly 1 stall cycle per hazard. The next cycle, the load has left EX, so luh drops and the pipeline resumes.
- Branch flush: 1 cycle of if_id_flush_o per taken branch. The IF/ID register applies flush after stall, so flush wins if both are asserted; rules 2–5 never assert both.
- luh with register 0 as destination never stalls.

## Test plan
- Load-use: ex_memread_i=1, ex_rt_i=5, id_rs_i=5 for one cycle -> pc_write_o=0, if_id_stall_o=1, id_ex_bubble_o=1 in that cycle; the next cycle (ex_memread_i=0) outputs return to defaults; stall_cnt_o=1.
- Zero register and rt gating: ex_rt_i=0=id_rs_i gives no stall. ex_rt_i=7=id_rt_i with id_uses_rt_i=0 gives no stall; with id_uses_rt_i=1, a 1-cycle stall.
- MUL/DIV freeze: MDU_LAT=4, mdu_start_i pulse -> pc_write_o=0, if_id_stall_o=1, id_ex_stall_o=1 for exactly 3 cycles; a simultaneous luh and branch_taken_i produce no bubble or flush. Repeat with MDU_LAT=2 -> 1 frozen cycle and the FSM never enters MDU_WAIT.
- Branch with fetch miss: branch_taken_i=1 with imem_ready_i=0 -> pc_write_o=1, if_id_flush_o=1. Then imem_ready_i=0 alone -> pc_write_o=0, if_id_flush_o=1; flush_cnt_o=2.
- Load-use with branch: luh=1 and branch_taken_i=1 in the same cycle -> stall asserted, if_id_flush_o=0.
- Reset and saturation: assert rst_i=0 during the second MDU_WAIT cycle -> rule-1 outputs, counters 0, and RUN after release. Separately, with CNT_W=4, 20 fetch-miss cycles -> stall_cnt_o and flush_cnt_o both hold at 15.
